// File: rtl/eth_f_pkt_client_checker_gen2.sv
// Receive-side packet checker for an Ethernet client loopback.
// Compares each accepted beat against WORDS copies of an incrementing
// reference lane, validates SOP/EOP framing and collects error/traffic stats.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rx_*                    receive beat (valid/sop/eop/empty/data/error)
//   i_cfg_en                  run the checker; low holds it idle and cleared
//   i_cfg_resync_sop          reload the reference from SEED on every SOP
//   i_cfg_exp_pkts            packets to receive before done (0 = unbounded)
//   i_stat_clr                clear error statistics and traffic counters
//   o_data_error/o_frame_error sticky error flags
//   o_err_pulse               one-cycle pulse two cycles after an errored beat
//   o_err_cnt, o_pkt_cnt, o_byte_cnt, o_num_ticks  statistics
//   o_done                    expected packet count reached
//   o_first_err_pkt/beat      location of first error since clear
module eth_f_pkt_client_checker_gen2 #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ERR_W = 7,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(64'h7060504030201000),
  localparam int unsigned DW      = WORDS * WIDTH,
  localparam int unsigned BYTES   = DW / 8,
  localparam int unsigned EMPTY_W = $clog2(BYTES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_valid,
  input  logic               i_rx_sop,
  input  logic               i_rx_eop,
  input  logic [EMPTY_W-1:0] i_rx_empty,
  input  logic [DW-1:0]      i_rx_data,
  input  logic [ERR_W-1:0]   i_rx_error,
  input  logic               i_cfg_en,
  input  logic               i_cfg_resync_sop,
  input  logic [CNT_W-1:0]   i_cfg_exp_pkts,
  input  logic               i_stat_clr,
  output logic               o_data_error,
  output logic               o_frame_error,
  output logic               o_err_pulse,
  output logic [CNT_W-1:0]   o_err_cnt,
  output logic [CNT_W-1:0]   o_pkt_cnt,
  output logic [63:0]        o_byte_cnt,
  output logic [63:0]        o_num_ticks,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_first_err_pkt,
  output logic [15:0]        o_first_err_beat
);

  typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DONE} state_t;

  state_t             r_state, w_state_next;
  logic               w_frame_err;
  logic [WIDTH-1:0]   r_ref;
  logic [15:0]        r_beat_idx;
  logic               r_s1_valid, r_s1_frame, r_s1_mac;
  logic [DW-1:0]      r_s1_data, r_s1_exp;
  logic [CNT_W-1:0]   r_s1_pkt;
  logic [15:0]        r_s1_beat;
  logic               r_err_pulse, r_data_error, r_frame_error, r_done;
  logic               r_first_seen, r_ticks_run;
  logic [CNT_W-1:0]   r_err_cnt, r_pkt_cnt, r_first_err_pkt;
  logic [15:0]        r_first_err_beat;
  logic [63:0]        r_byte_cnt, r_num_ticks;

  // Stage 0: accept, build expected beat and byte mask
  logic               w_acc;
  logic [WIDTH-1:0]   w_ref_use;
  logic [EMPTY_W+2:0] w_shamt;
  logic [DW-1:0]      w_mask;
  logic [15:0]        w_beat_idx;
  logic               w_pkt_inc, w_tick_inc;
  logic [63:0]        w_byte_inc;

  assign w_acc      = i_rx_valid & i_cfg_en;
  assign w_ref_use  = (i_cfg_resync_sop && i_rx_sop) ? SEED : r_ref;
  assign w_shamt    = {i_rx_empty, 3'b000};
  assign w_mask     = i_rx_eop ? ({DW{1'b1}} << w_shamt) : {DW{1'b1}};
  assign w_beat_idx = i_rx_sop ? 16'd0 : r_beat_idx;
  assign w_pkt_inc  = w_acc & i_rx_eop;
  assign w_byte_inc = !w_acc ? 64'd0 :
                      (i_rx_eop ? 64'(BYTES) - 64'(i_rx_empty) : 64'(BYTES));
  assign w_tick_inc = i_cfg_en & (r_ticks_run | w_acc) & ~r_done;

  // Stage 2 compare, evaluated on stage-1 registers
  logic w_mis, w_err;
  assign w_mis = r_s1_valid & (r_s1_data != r_s1_exp);
  assign w_err = r_s1_valid & ((r_s1_data != r_s1_exp) | r_s1_frame | r_s1_mac);

  // Framing FSM: next state and framing-error decode
  always_comb begin
    w_state_next = r_state;
    w_frame_err  = 1'b0;
    if (!i_cfg_en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (!i_rx_sop)      w_frame_err  = 1'b1;
            else if (!i_rx_eop) w_state_next = ST_IN_PKT;
          end
          // Completion has priority over starting a new packet
          if ((i_cfg_exp_pkts != '0) && (r_pkt_cnt >= i_cfg_exp_pkts))
            w_state_next = ST_DONE;
        end
        ST_IN_PKT: begin
          if (w_acc) begin
            if (i_rx_sop) w_frame_err  = 1'b1;
            if (i_rx_eop) w_state_next = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (w_acc && !i_rx_sop) w_frame_err = 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  // Reference lane, beat index and stage-1 pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ref      <= SEED;
      r_beat_idx <= '0;
      r_s1_valid <= 1'b0;
      r_s1_frame <= 1'b0;
      r_s1_mac   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_exp   <= '0;
      r_s1_pkt   <= '0;
      r_s1_beat  <= '0;
    end else begin
      if (!i_cfg_en)  r_ref <= SEED;
      else if (w_acc) r_ref <= w_ref_use + WIDTH'(1);
      if (w_acc)
        r_beat_idx <= (w_beat_idx == 16'hFFFF) ? 16'hFFFF : w_beat_idx + 16'd1;
      r_s1_valid <= w_acc;
      r_s1_frame <= w_frame_err;
      r_s1_mac   <= i_rx_eop & (|i_rx_error);
      r_s1_data  <= i_rx_data & w_mask;
      r_s1_exp   <= {WORDS{w_ref_use}} & w_mask;
      r_s1_pkt   <= r_pkt_cnt;
      r_s1_beat  <= w_beat_idx;
    end
  end

  // Error statistics; a clear loads the same-cycle event instead of dropping it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_pulse      <= 1'b0;
      r_data_error     <= 1'b0;
      r_frame_error    <= 1'b0;
      r_err_cnt        <= '0;
      r_first_seen     <= 1'b0;
      r_first_err_pkt  <= '0;
      r_first_err_beat <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (i_stat_clr) begin
        r_data_error     <= w_mis;
        r_frame_error    <= r_s1_valid & r_s1_frame;
        r_err_cnt        <= CNT_W'(w_err);
        r_first_seen     <= w_err;
        r_first_err_pkt  <= w_err ? r_s1_pkt : '0;
        r_first_err_beat <= w_err ? r_s1_beat : '0;
      end else begin
        r_data_error  <= r_data_error | w_mis;
        r_frame_error <= r_frame_error | (r_s1_valid & r_s1_frame);
        if (w_err && (r_err_cnt != {CNT_W{1'b1}}))
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (w_err && !r_first_seen) begin
          r_first_seen     <= 1'b1;
          r_first_err_pkt  <= r_s1_pkt;
          r_first_err_beat <= r_s1_beat;
        end
      end
    end
  end

  // Traffic counters, cleared while the checker is disabled
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_cfg_en) begin
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_num_ticks <= '0;
      r_ticks_run <= 1'b0;
    end else begin
      if (w_acc) r_ticks_run <= 1'b1;
      if (i_stat_clr) begin
        r_pkt_cnt   <= CNT_W'(w_pkt_inc);
        r_byte_cnt  <= w_byte_inc;
        r_num_ticks <= 64'(w_tick_inc);
      end else begin
        r_pkt_cnt   <= r_pkt_cnt + CNT_W'(w_pkt_inc);
        r_byte_cnt  <= r_byte_cnt + w_byte_inc;
        r_num_ticks <= r_num_ticks + 64'(w_tick_inc);
      end
    end
  end

  assign o_data_error     = r_data_error;
  assign o_frame_error    = r_frame_error;
  assign o_err_pulse      = r_err_pulse;
  assign o_err_cnt        = r_err_cnt;
  assign o_pkt_cnt        = r_pkt_cnt;
  assign o_byte_cnt       = r_byte_cnt;
  assign o_num_ticks      = r_num_ticks;
  assign o_done           = r_done;
  assign o_first_err_pkt  = r_first_err_pkt;
  assign o_first_err_beat = r_first_err_beat;

endmodule
